result_broadcast: RTL and testbench
===================================

# result_broadcast

Execution-side result broadcast unit: collects completed results (physical destination map, 32-bit value, ROB tag) from the functional units and drives the single tag/value broadcast bus consumed by the issue queue (operand wakeup), the busy table and the ROB. Each source has its own small FIFO. One result is granted per cycle by round-robin and held on registered outputs until the pipeline is not stalled. It sits between the execution units and the issue/rename/ROB consumers of `exe_broadcast`.

## Interface
- `NUM_SRC`, 3: number of result sources (0 = ALU, 1 = MUL/DIV, 2 = load).
- `DEPTH`, 4: per-source FIFO depth; power of two, ≥2.
- `ROB_W`, 5: ROB tag width.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `STALL`  in  1  pipeline stall; when high, the broadcast on the bus is not consumed.
- `FLUSH`  in  1  synchronous flush; discards all buffered and displayed results.
- `src_valid`  in  NUM_SRC  per-source result-valid.
- `src_map`  in  6*NUM_SRC  per-source destination physical map; source s occupies bits [6s+5:6s].
- `src_val`  in  32*NUM_SRC  per-source result value.
- `src_rob`  in  ROB_W*NUM_SRC  per-source ROB tag.
- `src_ready`  out  NUM_SRC  per-source FIFO not full.
- `exe_broadcast`  out  1  broadcast valid.
- `exe_broadcast_map`  out  6  broadcast destination map.
- `exe_broadcast_val`  out  32  broadcast value.
- `exe_broadcast_rob`  out  ROB_W  broadcast ROB tag.
- `exe_broadcast_src`  out  2  index of the granted source.
- `idle`  out  1  all FIFOs empty and no broadcast displayed.
- `bcast_count`  out  32  number of broadcasts consumed.

## Operation
- **Push:** a source is accepted when `src_valid[s] & src_ready[s] & !FLUSH`, and the entry is written at FIFO tail s. If `src_valid` is high while `src_ready` is low, the entry is ignored; the source must hold it.
- `src_ready[s] = (count[s] != DEPTH)`. This is derived from the registered count only; there is no same-cycle pop pass-through.
- **Output register:** `exe_broadcast` and its fields are registers. The current broadcast is consumed at any edge where `exe_broadcast & !STALL`.
- **Load rule, at each edge without FLUSH:**
  - If `!exe_broadcast | !STALL`, the register loads the granted FIFO head (pop it, set `exe_broadcast=1`). If no FIFO is non-empty, it clears (`exe_broadcast=0`).
  - Otherwise the register holds all fields unchanged.
- **Arbitration:** round-robin over non-empty FIFOs. The search starts at `(rr_last+1) mod NUM_SRC`. `rr_last` updates to the granted index only on a load. Nothing is granted while holding.
- **Map 0:** results with map 0 (no destination) are broadcast like any other result. Consumers treat map 0 as always ready; the ROB still needs the completion.
- **`bcast_count`:** increments by 1 on each consumed broadcast and wraps at 2^32.
- **FLUSH:** at the edge, all FIFO pointers and counts are zeroed and `exe_broadcast` is cleared. Pushes in the FLUSH cycle are dropped. `rr_last` and `bcast_count` are kept. FLUSH has priority over STALL and over push.
- **Pointers:** head and tail are log2(DEPTH)-bit and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits. A simultaneous push and pop on the same FIFO leaves the count unchanged.
- **`idle`** = `(all count==0) & !exe_broadcast`, combinational.

## Timing
- **Reset (async, RESET low):**
  - All FIFOs empty.
  - `exe_broadcast=0`; map, val, rob and src outputs 0.
  - `rr_last=NUM_SRC-1`, so source 0 has priority on the first grant.
  - `bcast_count=0`.
  - `src_ready` all 1; `idle=1`.
  - A reset assertion mid-operation discards everything in the same way.
- **Latency:** an entry accepted at edge k appears on the bus after edge k+1 at the earliest. This holds when the bus is free or consumed at k+1, and the source wins arbitration.
- **Throughput:** at most one broadcast per unstalled cycle. A back-to-back stream from any mix of sources sustains 1 per cycle.
- **Stall:** a broadcast displayed while STALL is high stays valid and unchanged for every stalled cycle. It is consumed at the first edge with STALL low. No result is ever lost or duplicated.
- **Full FIFO:** `src_ready[s]` falls in the cycle after the DEPTH-th push is accepted. It rises in the cycle after the first pop.

## Test plan
- **Single result:** after reset, push src1 `{map=0x0A, val=0x12345678, rob=3}` at edge 1 → after edge 2, `exe_broadcast=1`, `map=0x0A`, `val=0x12345678`, `rob=3`, `src=1` for one cycle; then `idle=1` and `bcast_count=1`.
- **Round-robin fairness:** push all 3 sources every cycle for 6 cycles (src0 vals 0x100+n, src1 0x200+n, src2 0x300+n) → grant order 0,1,2,0,1,2…; no source starves. Each source's values come out in FIFO order.
- **Stall hold:** broadcast `map=5` displayed, hold STALL high for 3 cycles → bus unchanged for all 4 cycles and `bcast_count` unchanged. After STALL drops, the next entry follows and `count` increments by exactly 1.
- **Full/backpressure:** with STALL high, push src2 5 times → `src_ready[2]=0` after the 4th acceptance and the 5th entry is not accepted. Release STALL → 4 broadcasts in order, then the 5th once re-pushed.
- **Flush:** 2 entries buffered in src0, 1 displayed, push on src1 in the FLUSH cycle → after the edge, `exe_broadcast=0`, `idle=1` and nothing is broadcast later. `bcast_count` is unchanged.
- **Async reset mid-stream:** assert RESET between edges while the bus is active → outputs are cleared immediately. After release, the first new push from src0 and src2 in the same cycle grants src0 first.

Source files
------------

// File: rtl/result_broadcast.sv
`default_nettype none
// ============================================================================
// Module   : result_broadcast
// Purpose  : Collects completed results from the functional units into
//            per-source FIFOs and drives the single registered tag/value
//            broadcast bus (issue-queue wakeup, busy table, ROB), one result
//            per cycle by round-robin, held while the pipeline is stalled.
// Revision : 1.0  initial release
// ============================================================================
module result_broadcast #(
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 4,
  parameter int ROB_W   = 5
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     STALL,
  input  logic                     FLUSH,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [6*NUM_SRC-1:0]     src_map,
  input  logic [32*NUM_SRC-1:0]    src_val,
  input  logic [ROB_W*NUM_SRC-1:0] src_rob,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic                     exe_broadcast,
  output logic [5:0]               exe_broadcast_map,
  output logic [31:0]              exe_broadcast_val,
  output logic [ROB_W-1:0]         exe_broadcast_rob,
  output logic [1:0]               exe_broadcast_src,
  output logic                     idle,
  output logic [31:0]              bcast_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // The source index leaves the block on a 2-bit field, so at most 4 sources.
  localparam int SRC_W = 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

  // One buffered result: destination map, value and ROB tag.
  typedef struct packed {
    logic [5:0]       map;
    logic [31:0]      val;
    logic [ROB_W-1:0] rob;
  } entry_t;

  // Per-source FIFO state.
  entry_t                          mem_q [NUM_SRC][DEPTH];
  entry_t                          mem_d [NUM_SRC][DEPTH];
  logic [NUM_SRC-1:0][PTR_W-1:0]   head_q, head_d;
  logic [NUM_SRC-1:0][PTR_W-1:0]   tail_q, tail_d;
  logic [NUM_SRC-1:0][CNT_W-1:0]   count_q, count_d;

  // Broadcast output register and arbitration / statistics state.
  logic                            bcast_q, bcast_d;
  entry_t                          bus_q, bus_d;
  logic [SRC_W-1:0]                src_q, src_d;
  logic [SRC_W-1:0]                rr_last_q, rr_last_d;
  logic [31:0]                     bcast_count_q, bcast_count_d;

  // Handshake and arbitration wires.
  entry_t                          src_ent [NUM_SRC];
  logic [NUM_SRC-1:0]              push;
  logic [NUM_SRC-1:0]              pop;
  logic                            grant_valid;
  logic [SRC_W-1:0]                grant_idx;
  logic [SRC_W-1:0]                cand;
  logic                            load_en;
  logic                            consume;

  // Slice the flat per-source input buses into entries.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_unpack
    assign src_ent[s] = {src_map[6*s +: 6], src_val[32*s +: 32], src_rob[ROB_W*s +: ROB_W]};
  end

  // Ready comes from the registered count only; pushes are dropped in a flush cycle.
  always_comb begin
    src_ready = '0;
    push      = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_ready[s] = (count_q[s] != FULL_CNT);
      push[s]      = src_valid[s] & src_ready[s] & ~FLUSH;
    end
  end

  // Round-robin search over non-empty FIFOs, starting just after the last grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = SRC_W'((32'(rr_last_q) + 32'(i) + 32'd1) % 32'(NUM_SRC));
      if (!grant_valid && (count_q[cand] != '0)) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // The output register reloads when empty or being consumed; a held broadcast blocks any grant.
  always_comb begin
    load_en = ~FLUSH & (~bcast_q | ~STALL);
    consume = bcast_q & ~STALL & ~FLUSH;
    pop     = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      pop[s] = load_en & grant_valid & (grant_idx == SRC_W'(s));
    end
  end

  // FIFO pointer and occupancy update; flush empties every FIFO.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (FLUSH) begin
        head_d[s]  = '0;
        tail_d[s]  = '0;
        count_d[s] = '0;
      end else begin
        if (push[s]) tail_d[s] = tail_q[s] + 1'b1;
        if (pop[s])  head_d[s] = head_q[s] + 1'b1;
        case ({push[s], pop[s]})
          2'b10:   count_d[s] = count_q[s] + 1'b1;
          2'b01:   count_d[s] = count_q[s] - 1'b1;
          default: count_d[s] = count_q[s];
        endcase
      end
    end
  end

  // Accepted results are written at the FIFO tail.
  always_comb begin
    mem_d = mem_q;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (push[s]) mem_d[s][tail_q[s]] = src_ent[s];
    end
  end

  // Next broadcast: clear on flush, load the granted head or go empty, else hold.
  always_comb begin
    bcast_d       = bcast_q;
    bus_d         = bus_q;
    src_d         = src_q;
    rr_last_d     = rr_last_q;
    bcast_count_d = bcast_count_q;
    if (consume) bcast_count_d = bcast_count_q + 32'd1;
    if (FLUSH) begin
      bcast_d = 1'b0;
      bus_d   = '0;
      src_d   = '0;
    end else if (load_en) begin
      if (grant_valid) begin
        bcast_d   = 1'b1;
        bus_d     = mem_q[grant_idx][head_q[grant_idx]];
        src_d     = grant_idx;
        rr_last_d = grant_idx;
      end else begin
        bcast_d = 1'b0;
        bus_d   = '0;
        src_d   = '0;
      end
    end
  end

  // Entry storage needs no reset: validity is tracked by the counts.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  // Control state with asynchronous active-low reset; source 0 wins the first grant.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      bcast_q       <= 1'b0;
      bus_q         <= '0;
      src_q         <= '0;
      rr_last_q     <= LAST_SRC;
      bcast_count_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      bcast_q       <= bcast_d;
      bus_q         <= bus_d;
      src_q         <= src_d;
      rr_last_q     <= rr_last_d;
      bcast_count_q <= bcast_count_d;
    end
  end

  // Idle when nothing is buffered and nothing is displayed.
  always_comb begin
    idle = (count_q == '0) & ~bcast_q;
  end

  assign exe_broadcast     = bcast_q;
  assign exe_broadcast_map = bus_q.map;
  assign exe_broadcast_val = bus_q.val;
  assign exe_broadcast_rob = bus_q.rob;
  assign exe_broadcast_src = src_q;
  assign bcast_count       = bcast_count_q;

endmodule
`default_nettype wire

// File: tb/tb_result_broadcast.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_broadcast
// Purpose  : Self-checking bench for result_broadcast: vector table for single
//            results, scripted sequences for round-robin, stall, backpressure,
//            flush and asynchronous reset, plus a per-source scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_result_broadcast;

  localparam int NUM_SRC = 3;
  localparam int DEPTH   = 4;
  localparam int ROB_W   = 5;

  logic                     CLK = 1'b0;
  logic                     RESET;
  logic                     STALL;
  logic                     FLUSH;
  logic [NUM_SRC-1:0]       src_valid;
  logic [6*NUM_SRC-1:0]     src_map;
  logic [32*NUM_SRC-1:0]    src_val;
  logic [ROB_W*NUM_SRC-1:0] src_rob;
  logic [NUM_SRC-1:0]       src_ready;
  logic                     exe_broadcast;
  logic [5:0]               exe_broadcast_map;
  logic [31:0]              exe_broadcast_val;
  logic [ROB_W-1:0]         exe_broadcast_rob;
  logic [1:0]               exe_broadcast_src;
  logic                     idle;
  logic [31:0]              bcast_count;

  result_broadcast #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .STALL             (STALL),
    .FLUSH             (FLUSH),
    .src_valid         (src_valid),
    .src_map           (src_map),
    .src_val           (src_val),
    .src_rob           (src_rob),
    .src_ready         (src_ready),
    .exe_broadcast     (exe_broadcast),
    .exe_broadcast_map (exe_broadcast_map),
    .exe_broadcast_val (exe_broadcast_val),
    .exe_broadcast_rob (exe_broadcast_rob),
    .exe_broadcast_src (exe_broadcast_src),
    .idle              (idle),
    .bcast_count       (bcast_count)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  // Scoreboard: accepted entries, consumed per source in acceptance order.
  typedef struct {
    int          src;
    logic [42:0] ent;
  } sb_t;
  sb_t sbq[$];
  int  got_src[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_src(input int s, input logic [5:0] m, input logic [31:0] v, input logic [4:0] r);
    src_valid[s]       = 1'b1;
    src_map[6*s +: 6]  = m;
    src_val[32*s +: 32] = v;
    src_rob[5*s +: 5]  = r;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (!idle && c < 50) begin
      tick();
      c++;
    end
    chk(name, 64'(idle), 64'd1);
  endtask

  // Monitor: consumption compared against the scoreboard, acceptances recorded.
  always @(negedge CLK) begin : monitor
    int          idx;
    logic [42:0] act;
    sb_t         e;
    idx = -1;
    act = {exe_broadcast_map, exe_broadcast_val, exe_broadcast_rob};
    if (RESET && FLUSH) begin
      sbq.delete();
    end else if (RESET) begin
      if (exe_broadcast && !STALL) begin
        for (int k = 0; k < sbq.size(); k++)
          if (idx < 0 && sbq[k].src == int'(exe_broadcast_src)) idx = k;
        if (idx < 0) begin
          n_total++;
          $display("FAIL bus_unexpected: got src %0d entry 0x%0h, required no broadcast", exe_broadcast_src, act);
        end else begin
          chk($sformatf("bus_entry_src%0d", exe_broadcast_src), 64'(act), 64'(sbq[idx].ent));
          sbq.delete(idx);
        end
        got_src.push_back(int'(exe_broadcast_src));
      end
      for (int s = 0; s < NUM_SRC; s++) begin
        if (src_valid[s] && src_ready[s]) begin
          e.src = s;
          e.ent = {src_map[6*s +: 6], src_val[32*s +: 32], src_rob[5*s +: 5]};
          sbq.push_back(e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          src;
    logic [5:0]  map;
    logic [31:0] val;
    logic [4:0]  rob;
    logic [31:0] exp_count;
  } vec_t;

  initial begin : main
    vec_t       vecs[4];
    int         sent[3];
    logic [2:0] acc;
    int         exp_full[6];

    vecs[0] = '{1, 6'h0A, 32'h12345678, 5'd3,  32'd1};
    vecs[1] = '{0, 6'h00, 32'hDEADBEEF, 5'd31, 32'd2};
    vecs[2] = '{1, 6'h15, 32'h00000000, 5'd17, 32'd3};
    vecs[3] = '{2, 6'h3F, 32'hFFFFFFFF, 5'd0,  32'd4};

    RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    src_valid = '0; src_map = '0; src_val = '0; src_rob = '0;
    #12;
    chk("reset_bcast", 64'(exe_broadcast), 64'd0);
    chk("reset_fields", 64'({exe_broadcast_map, exe_broadcast_val, exe_broadcast_rob, exe_broadcast_src}), 64'd0);
    chk("reset_ready", 64'(src_ready), 64'h7);
    chk("reset_idle", 64'(idle), 64'd1);
    chk("reset_count", 64'(bcast_count), 64'd0);
    RESET = 1'b1;
    tick();

    // Single results, including map 0 and all-ones / all-zero values.
    for (int i = 0; i < 4; i++) begin
      set_src(vecs[i].src, vecs[i].map, vecs[i].val, vecs[i].rob);
      tick();
      src_valid = '0;
      chk($sformatf("vec%0d_latency", i), 64'(exe_broadcast), 64'd0);
      tick();
      chk($sformatf("vec%0d_bcast", i), 64'(exe_broadcast), 64'd1);
      chk($sformatf("vec%0d_map", i), 64'(exe_broadcast_map), 64'(vecs[i].map));
      chk($sformatf("vec%0d_val", i), 64'(exe_broadcast_val), 64'(vecs[i].val));
      chk($sformatf("vec%0d_rob", i), 64'(exe_broadcast_rob), 64'(vecs[i].rob));
      chk($sformatf("vec%0d_src", i), 64'(exe_broadcast_src), 64'(vecs[i].src));
      tick();
      chk($sformatf("vec%0d_clear", i), 64'(exe_broadcast), 64'd0);
      chk($sformatf("vec%0d_idle", i), 64'(idle), 64'd1);
      chk($sformatf("vec%0d_count", i), 64'(bcast_count), 64'(vecs[i].exp_count));
    end

    // Round-robin: all three sources stream 6 results each, holding under backpressure.
    got_src.delete();
    sent = '{0, 0, 0};
    for (int c = 0; c < 100 && (sent[0] < 6 || sent[1] < 6 || sent[2] < 6); c++) begin
      for (int s = 0; s < 3; s++) begin
        if (sent[s] < 6) set_src(s, 6'(s + 1), 32'(32'h100 * (s + 1) + sent[s]), 5'(s));
        else src_valid[s] = 1'b0;
      end
      acc = src_valid & src_ready;
      tick();
      for (int s = 0; s < 3; s++) if (acc[s]) sent[s]++;
    end
    src_valid = '0;
    drain("rr_drain");
    chk("rr_grants", 64'(got_src.size()), 64'd18);
    for (int i = 0; i < got_src.size() && i < 18; i++)
      chk($sformatf("rr_order%0d", i), 64'(got_src[i]), 64'(i % 3));
    chk("rr_count", 64'(bcast_count), 64'd22);

    // Stall hold: map 5 stays on the bus for four cycles, then map 9 follows.
    got_src.delete();
    set_src(0, 6'd5, 32'hA5A50005, 5'd7);
    tick();
    set_src(0, 6'd9, 32'hA5A50009, 5'd8);
    STALL = 1'b1;
    tick();
    src_valid = '0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("stall%0d_bus", c),
          64'({exe_broadcast, exe_broadcast_map, exe_broadcast_val, exe_broadcast_rob, exe_broadcast_src}),
          64'({1'b1, 6'd5, 32'hA5A50005, 5'd7, 2'd0}));
      chk($sformatf("stall%0d_count", c), 64'(bcast_count), 64'd22);
      if (c < 3) tick();
    end
    STALL = 1'b0;
    tick();
    chk("stall_next_map", 64'({exe_broadcast, exe_broadcast_map, exe_broadcast_rob}), 64'({1'b1, 6'd9, 5'd8}));
    chk("stall_next_count", 64'(bcast_count), 64'd23);
    tick();
    chk("stall_end_bcast", 64'(exe_broadcast), 64'd0);
    chk("stall_end_count", 64'(bcast_count), 64'd24);
    chk("stall_grants", 64'(got_src.size()), 64'd2);

    // Backpressure: bus held by a src0 result while src2 offers five results.
    got_src.delete();
    set_src(0, 6'h11, 32'h0000D0D0, 5'd1);
    tick();
    src_valid = '0;
    STALL = 1'b1;
    tick();
    chk("full_dummy_bcast", 64'(exe_broadcast), 64'd1);
    for (int k = 0; k < 5; k++) begin
      set_src(2, 6'(8'h20 + k), 32'(32'hF000 + k), 5'(k));
      chk($sformatf("full_ready%0d", k), 64'(src_ready[2]), 64'(k < 4));
      tick();
    end
    tick();
    chk("full_ready_held", 64'(src_ready), 64'b011);
    STALL = 1'b0;
    tick();
    chk("full_ready_rise", 64'(src_ready[2]), 64'd1);
    tick();
    src_valid = '0;
    drain("full_drain");
    exp_full = '{0, 2, 2, 2, 2, 2};
    chk("full_grants", 64'(got_src.size()), 64'd6);
    for (int i = 0; i < got_src.size() && i < 6; i++)
      chk($sformatf("full_order%0d", i), 64'(got_src[i]), 64'(exp_full[i]));
    chk("full_count", 64'(bcast_count), 64'd30);

    // Flush: one displayed, two buffered in src0, a src1 push in the flush cycle.
    got_src.delete();
    STALL = 1'b1;
    set_src(0, 6'd1, 32'hCAFE0001, 5'd1);
    tick();
    set_src(0, 6'd2, 32'hCAFE0002, 5'd2);
    tick();
    set_src(0, 6'd3, 32'hCAFE0003, 5'd3);
    tick();
    src_valid = '0;
    chk("flush_pre_bus", 64'({exe_broadcast, exe_broadcast_map, idle}), 64'({1'b1, 6'd1, 1'b0}));
    FLUSH = 1'b1;
    set_src(1, 6'h2A, 32'h00000BAD, 5'd9);
    tick();
    FLUSH = 1'b0;
    src_valid = '0;
    STALL = 1'b0;
    chk("flush_bcast", 64'(exe_broadcast), 64'd0);
    chk("flush_idle", 64'(idle), 64'd1);
    chk("flush_ready", 64'(src_ready), 64'h7);
    chk("flush_count", 64'(bcast_count), 64'd30);
    repeat (5) tick();
    chk("flush_quiet", 64'({got_src.size() != 0, exe_broadcast, idle}), 64'b001);
    chk("flush_count_after", 64'(bcast_count), 64'd30);

    // Asynchronous reset with a broadcast on the bus.
    STALL = 1'b1;
    set_src(1, 6'h33, 32'h00000077, 5'd4);
    tick();
    src_valid = '0;
    tick();
    chk("arst_pre_bcast", 64'(exe_broadcast), 64'd1);
    #2 RESET = 1'b0;
    #1;
    chk("arst_bcast", 64'(exe_broadcast), 64'd0);
    chk("arst_fields", 64'({exe_broadcast_map, exe_broadcast_val, exe_broadcast_rob, exe_broadcast_src}), 64'd0);
    chk("arst_ready_idle", 64'({src_ready, idle}), 64'hF);
    chk("arst_count", 64'(bcast_count), 64'd0);
    sbq.delete();
    got_src.delete();
    RESET = 1'b1;
    STALL = 1'b0;
    set_src(0, 6'h01, 32'h0000A000, 5'd10);
    set_src(2, 6'h02, 32'h0000C000, 5'd12);
    tick();
    src_valid = '0;
    drain("arst_drain");
    chk("arst_grants", 64'(got_src.size()), 64'd2);
    if (got_src.size() == 2) begin
      chk("arst_first", 64'(got_src[0]), 64'd0);
      chk("arst_second", 64'(got_src[1]), 64'd2);
    end
    chk("arst_count_after", 64'(bcast_count), 64'd2);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
